// File: rtl/approx_mult_pkg.sv
// Shared constants and elaboration-time helpers for the approximate tiled multiplier.
// Tile geometry, tree depth and pipeline latency are all derived from WIDTH here.
package approx_mult_pkg;

    localparam int TILE_W = 4;

    function automatic int ceil_log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int tiles_per_row(input int width);
        return width / TILE_W;
    endfunction

    function automatic int n_tiles(input int width);
        return tiles_per_row(width) * tiles_per_row(width);
    endfunction

    function automatic int tree_levels(input int width);
        return ceil_log2(n_tiles(width));
    endfunction

    function automatic int pipe_latency(input int width);
        return 2 + tree_levels(width);
    endfunction

    // Number of live nodes at tree level k when the tree starts with t leaves.
    function automatic int level_nodes(input int t, input int k);
        return (t + (1 << k) - 1) >> k;
    endfunction

    function automatic int tile_i(input int t, input int width);
        return t % tiles_per_row(width);
    endfunction

    function automatic int tile_j(input int t, input int width);
        return t / tiles_per_row(width);
    endfunction

    function automatic int tile_shift(input int t, input int width);
        return TILE_W * (tile_i(t, width) + tile_j(t, width));
    endfunction

endpackage

// File: rtl/approx_mult_pipe_tile.sv
// Combinational 4x4 multiplier tile with an optional carry-suppressed approximation.
// In approx mode columns 0..2 are ORed instead of summed; columns 3..6 stay exact.
module lm_tile_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       approx,
    output logic [7:0] p
);

    logic [2:0] low_or;
    logic [7:0] high_sum;
    logic [7:0] exact;

    always_comb begin
        low_or   = '0;
        high_sum = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i + k < 3)
                    low_or[i+k] = low_or[i+k] | (a[i] & b[k]);
                else
                    high_sum = high_sum + (8'(a[i] & b[k]) << (i + k));
            end
        end
    end

    assign exact = {4'b0, a} * {4'b0, b};
    assign p     = approx ? (high_sum + {5'b0, low_or}) : exact;

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined WIDTHxWIDTH unsigned multiplier from 4x4 tiles with a registered adder tree.
// Define APPROX_MULT_ERRSTAT_EN to add an exact shadow product and the err_cnt statistic.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_DIAG = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_approx
`ifdef APPROX_MULT_ERRSTAT_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        err_cnt
`endif
);

    localparam int PW  = 2 * WIDTH;
    localparam int NT  = n_tiles(WIDTH);
    localparam int NLV = tree_levels(WIDTH);
    localparam int LAT = pipe_latency(WIDTH);

    logic             run;
    logic             en;
    logic             accept;
    logic [LAT-1:0]   vld;
    logic [LAT-1:0]   mode;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [PW-1:0]    tile_ext [NT];
    logic [PW-1:0]    tree [0:NLV][0:2*NT-1];

    // run keeps in_ready low until the first edge after reset release.
    assign en        = !out_valid || out_ready;
    assign in_ready  = run && en;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld[LAT-1];
    assign out_approx = mode[LAT-1];
    assign out_p     = tree[NLV][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= 1'b0;
            vld  <= '0;
            mode <= '0;
            s1_a <= '0;
            s1_b <= '0;
        end else begin
            run <= 1'b1;
            if (en) begin
                vld  <= {vld[LAT-2:0], accept};
                mode <= {mode[LAT-2:0], in_approx};
                s1_a <= in_a;
                s1_b <= in_b;
            end
        end
    end

    for (genvar t = 0; t < NT; t++) begin : g_tile
        localparam int TI = tile_i(t, WIDTH);
        localparam int TJ = tile_j(t, WIDTH);
        localparam int SH = tile_shift(t, WIDTH);
        logic [7:0] tile_p;

        lm_tile_4x4 u_tile (
            .a      (s1_a[TILE_W*TI +: TILE_W]),
            .b      (s1_b[TILE_W*TJ +: TILE_W]),
            .approx (s1_approx_gate(mode[0], TI + TJ)),
            .p      (tile_p)
        );

        assign tile_ext[t] = PW'(tile_p) << SH;
    end

    function automatic logic s1_approx_gate(input logic m, input int diag_idx);
        return m && (diag_idx < APPROX_DIAG);
    endfunction

    // Level 0 holds the shifted tile products; each further level pairs neighbours,
    // an odd leftover node is simply re-registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NLV; k++)
                for (int m = 0; m < 2*NT; m++)
                    tree[k][m] <= '0;
        end else if (en) begin
            for (int m = 0; m < NT; m++)
                tree[0][m] <= tile_ext[m];
            for (int k = 1; k <= NLV; k++) begin
                for (int m = 0; m < NT; m++) begin
                    if (m < level_nodes(NT, k)) begin
                        if (2*m + 1 < level_nodes(NT, k - 1))
                            tree[k][m] <= tree[k-1][2*m] + tree[k-1][2*m+1];
                        else
                            tree[k][m] <= tree[k-1][2*m];
                    end
                end
            end
        end
    end

`ifdef APPROX_MULT_ERRSTAT_EN
    logic [PW-1:0] exact_q [0:NLV];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NLV; k++)
                exact_q[k] <= '0;
        end else if (en) begin
            exact_q[0] <= PW'(s1_a) * PW'(s1_b);
            for (int k = 1; k <= NLV; k++)
                exact_q[k] <= exact_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (stat_clr)
            err_cnt <= '0;
        else if (out_valid && out_ready && (out_p != exact_q[NLV]) && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe at WIDTH=8 (diag 1 and diag 0 instances in lockstep).
// Define APPROX_MULT_ERRSTAT_EN to also exercise err_cnt and stat_clr.
module tb_approx_mult_pipe;

    typedef struct packed {
        logic [15:0] p;
        logic        m;
        logic [15:0] p0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_approx = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_ready, out_valid, out_approx;
    logic        in_ready0, out_valid0, out_approx0;
    logic [15:0] out_p, out_p0;
`ifdef APPROX_MULT_ERRSTAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] err_cnt, err_cnt0;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    approx_mult_pipe #(.WIDTH(8), .APPROX_DIAG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .out_approx(out_approx)
`ifdef APPROX_MULT_ERRSTAT_EN
        , .stat_clr(stat_clr), .err_cnt(err_cnt)
`endif
    );

    approx_mult_pipe #(.WIDTH(8), .APPROX_DIAG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid0),
        .out_ready(out_ready), .out_p(out_p0), .out_approx(out_approx0)
`ifdef APPROX_MULT_ERRSTAT_EN
        , .stat_clr(stat_clr), .err_cnt(err_cnt0)
`endif
    );

    // Reference: exact tile product minus the exact low-column weight plus the ORed columns.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic m, input int diag);
        int acc, tile, c0, c1, c2, low_exact, low_or;
        logic [3:0] na, nb;
        acc = 0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                na = a[4*i +: 4];
                nb = b[4*j +: 4];
                tile = int'(na) * int'(nb);
                if (m && (i + j < diag)) begin
                    c0 = int'(na[0] & nb[0]);
                    c1 = int'(na[0] & nb[1]) + int'(na[1] & nb[0]);
                    c2 = int'(na[0] & nb[2]) + int'(na[1] & nb[1]) + int'(na[2] & nb[0]);
                    low_exact = c0 + 2*c1 + 4*c2;
                    low_or = c0 + ((c1 != 0) ? 2 : 0) + ((c2 != 0) ? 4 : 0);
                    tile = tile - low_exact + low_or;
                end
                acc = acc + (tile << (4*(i + j)));
            end
        end
        return acc[15:0];
    endfunction

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic rdy_in,
                        output logic acc, output logic xfer, output logic rdy,
                        output logic ov, output logic [15:0] p, output logic pm,
                        output logic [15:0] p0);
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_approx = m; out_ready = rdy_in;
        #1;
        rdy = in_ready; ov = out_valid; acc = v && in_ready; xfer = out_valid && rdy_in;
        p = out_p; pm = out_approx; p0 = out_p0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, expected 0", out_valid); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b, expected 0", in_ready); end
        if (out_p !== 16'd0) begin miscompares++; $display("FAIL rst_p: got %0d, expected 0", out_p); end
        if (out_approx !== 1'b0) begin miscompares++; $display("FAIL rst_approx: got %b, expected 0", out_approx); end
`ifdef APPROX_MULT_ERRSTAT_EN
        vectors++;
        if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_errcnt: got %0d, expected 0", err_cnt); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [7:0]  ta [4] = '{8'h03, 8'h03, 8'hFF, 8'hFF};
        logic        tm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] te [4] = '{16'd7, 16'd9, 16'd65015, 16'd65025};
        logic [15:0] t0 [4] = '{16'd9, 16'd9, 16'd65025, 16'd65025};
        logic acc, xfer, rdy, ov, pm;
        logic [15:0] p, p0;
        exp_t e;
        int idx = 0, n_acc = -1, n_out = -1;
        for (int n = 0; n < 40; n++) begin
            if (idx < 4) step(1'b1, ta[idx], ta[idx], tm[idx], 1'b1, acc, xfer, rdy, ov, p, pm, p0);
            else         step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
            if (acc) begin
                sb.push_back('{p: te[idx], m: tm[idx], p0: t0[idx]});
                if (n_acc < 0) n_acc = n;
                idx++;
            end
            if (ov && n_out < 0) n_out = n;
            if (xfer) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL dir_extra: got p=%0d, expected no result", p);
                end else begin
                    e = sb.pop_front();
                    if (p !== e.p || pm !== e.m || p0 !== e.p0) begin
                        miscompares++;
                        $display("FAIL dir_result: got p=%0d approx=%b p_diag0=%0d, expected p=%0d approx=%b p_diag0=%0d",
                                 p, pm, p0, e.p, e.m, e.p0);
                    end
                end
            end
            if (idx == 4 && sb.size() == 0) break;
        end
        vectors += 2;
        if (idx != 4 || sb.size() != 0) begin
            miscompares++; $display("FAIL dir_timeout: accepted %0d pending %0d, expected 4 and 0", idx, sb.size());
        end
        if (n_out - n_acc != 4) begin
            miscompares++; $display("FAIL dir_latency: got %0d cycles, expected 4", n_out - n_acc);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra [20];
        logic [7:0] rb [20];
        logic       rm [20];
        logic acc, xfer, rdy, ov, pm;
        logic [15:0] p, p0;
        exp_t e;
        int idx = 0, first_x = -1, last_x = -1, nx = 0;
        for (int i = 0; i < 20; i++) begin
            ra[i] = 8'($urandom_range(0, 255));
            rb[i] = 8'($urandom_range(0, 255));
            rm[i] = 1'($urandom_range(0, 1));
        end
        for (int n = 0; n < 100; n++) begin
            if (idx < 20) step(1'b1, ra[idx], rb[idx], rm[idx], 1'b1, acc, xfer, rdy, ov, p, pm, p0);
            else          step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
            if (acc) begin
                sb.push_back('{p: model(ra[idx], rb[idx], rm[idx], 1), m: rm[idx],
                               p0: model(ra[idx], rb[idx], rm[idx], 0)});
                idx++;
            end
            if (xfer) begin
                vectors++;
                if (first_x < 0) first_x = n;
                last_x = n; nx++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL b2b_extra: got p=%0d, expected no result", p);
                end else begin
                    e = sb.pop_front();
                    if (p !== e.p || pm !== e.m || p0 !== e.p0) begin
                        miscompares++;
                        $display("FAIL b2b_result: got p=%0d approx=%b p_diag0=%0d, expected p=%0d approx=%b p_diag0=%0d",
                                 p, pm, p0, e.p, e.m, e.p0);
                    end
                end
            end
            if (idx == 20 && sb.size() == 0) break;
        end
        vectors += 2;
        if (nx != 20 || sb.size() != 0) begin
            miscompares++; $display("FAIL b2b_count: got %0d results pending %0d, expected 20 and 0", nx, sb.size());
        end
        if (last_x - first_x != 19) begin
            miscompares++; $display("FAIL b2b_throughput: got span %0d cycles, expected 19", last_x - first_x);
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        logic [7:0] ra [12];
        logic [7:0] rb [12];
        logic acc, xfer, rdy, ov, pm, ordy;
        logic [15:0] p, p0, held;
        exp_t e;
        int idx = 0, nx = 0;
        held = '0;
        for (int i = 0; i < 12; i++) begin
            ra[i] = 8'($urandom_range(0, 255));
            rb[i] = 8'($urandom_range(0, 255));
        end
        for (int n = 0; n < 80; n++) begin
            ordy = !(n >= 7 && n <= 9);
            if (idx < 12) step(1'b1, ra[idx], rb[idx], 1'b1, ordy, acc, xfer, rdy, ov, p, pm, p0);
            else          step(1'b0, 8'h00, 8'h00, 1'b0, ordy, acc, xfer, rdy, ov, p, pm, p0);
            if (n == 7) held = p;
            if (n >= 7 && n <= 9) begin
                vectors += 3;
                if (ov !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b, expected 1", ov); end
                if (rdy !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b, expected 0", rdy); end
                if (p !== held) begin miscompares++; $display("FAIL bp_hold: got p=%0d, expected %0d", p, held); end
            end
            if (acc) begin
                sb.push_back('{p: model(ra[idx], rb[idx], 1'b1, 1), m: 1'b1,
                               p0: model(ra[idx], rb[idx], 1'b1, 0)});
                idx++;
            end
            if (xfer) begin
                vectors++; nx++;
                if (sb.size() == 0) begin
                    miscompares++; $display("FAIL bp_extra: got p=%0d, expected no result", p);
                end else begin
                    e = sb.pop_front();
                    if (p !== e.p || pm !== e.m) begin
                        miscompares++;
                        $display("FAIL bp_result: got p=%0d approx=%b, expected p=%0d approx=%b", p, pm, e.p, e.m);
                    end
                end
            end
            if (idx == 12 && sb.size() == 0) break;
        end
        vectors++;
        if (nx != 12 || sb.size() != 0) begin
            miscompares++; $display("FAIL bp_count: got %0d results pending %0d, expected 12 and 0", nx, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_inflight();
        logic acc, xfer, rdy, ov, pm;
        logic [15:0] p, p0;
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'(8'h11 * (i + 1)), 8'h0F, 1'b0, 1'b0, acc, xfer, rdy, ov, p, pm, p0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc, xfer, rdy, ov, p, pm, p0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc, xfer, rdy, ov, p, pm, p0);
        vectors++;
        if (ov !== 1'b1) begin miscompares++; $display("FAIL rif_pre_valid: got %b, expected 1", ov); end
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rif_valid: got %b, expected 0", out_valid); end
        if (out_p !== 16'd0) begin miscompares++; $display("FAIL rif_p: got %0d, expected 0", out_p); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
            vectors++;
            if (ov !== 1'b0) begin miscompares++; $display("FAIL rif_stale: got valid=%b p=%0d, expected valid 0", ov, p); end
        end
        sb.delete();
    endtask

`ifdef APPROX_MULT_ERRSTAT_EN
    task automatic test_errstat();
        logic [7:0] ta [3] = '{8'h03, 8'h03, 8'hFF};
        logic       tm [3] = '{1'b1, 1'b0, 1'b1};
        logic acc, xfer, rdy, ov, pm;
        logic [15:0] p, p0;
        int idx = 0, nx = 0;
        stat_clr = 1'b1;
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
        stat_clr = 1'b0;
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
        vectors++;
        if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL es_clr0: got %0d, expected 0", err_cnt); end
        for (int n = 0; n < 40 && nx < 3; n++) begin
            if (idx < 3) step(1'b1, ta[idx], ta[idx], tm[idx], 1'b1, acc, xfer, rdy, ov, p, pm, p0);
            else         step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
            if (acc) idx++;
            if (xfer) nx++;
        end
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
        vectors++;
        if (err_cnt !== 16'd2) begin miscompares++; $display("FAIL es_count: got %0d, expected 2", err_cnt); end
        stat_clr = 1'b1;
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
        stat_clr = 1'b0;
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc, xfer, rdy, ov, p, pm, p0);
        vectors++;
        if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL es_clr: got %0d, expected 0", err_cnt); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
`ifdef APPROX_MULT_ERRSTAT_EN
        test_errstat();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined NxN unsigned multiplier built from 4x4 tiles, where the low-order tiles can run in an approximate carry-suppressed mode selectable per transaction. Successor to the fixed 4x4 LUT-level approximate multipliers: same approximation style, generalised to WIDTH bits, with a runtime exact/approx mode and a valid/ready streaming interface. It sits between an operand source (e.g. a filter or MAC datapath) and a downstream accumulator.

## Interface
- WIDTH, 8: operand width; multiple of 4, range 8..32.
- APPROX_DIAG, 1: tile (i,j) is approximate when i+j < APPROX_DIAG, with i,j the 4-bit nibble indices of A and B; 0 makes every tile exact.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  unsigned multiplicand.
- in_b  in  WIDTH  unsigned multiplier.
- in_approx  in  1  1 = approximate mode for this transaction, 0 = exact.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_p  out  2*WIDTH  product.
- out_approx  out  1  mode the result was computed in.
- stat_clr  in  1  clear statistics (present only with APPROX_MULT_ERRSTAT_EN).
- err_cnt  out  16  count of results differing from exact (present only with APPROX_MULT_ERRSTAT_EN).

## Operation
- Operands are split into T=(WIDTH/4)^2 nibble tiles; each tile product is shifted by 4*(i+j) and summed.
- Exact tile: a*b, 8 bits.
- Approximate tile: columns 0..2 are the OR of their partial products a_i&b_k with no carry out; the sum of all partial products with i+k>=3 is added exactly. Examples: 3x3 -> 7; 15x15 -> 215.
- A tile uses the approximate rule only when in_approx=1 and i+j < APPROX_DIAG.
- The adder tree is a binary tree of 2*WIDTH-bit adders, with one register level per tree level. Odd leftovers pass through a register.
- Accumulation is full width, so no overflow is possible.
- in_approx travels with the data and appears on out_approx.

## Timing
- Stage 1 registers the operands and mode. Stage 2 registers the tile products. Stages 3..L each register one tree level.
- Latency L = 2 + ceil(log2 T) cycles from accept to out_valid: 4 for WIDTH=8, 6 for WIDTH=16.
- Throughput is 1 result per cycle with no stall.
- Global enable en = !out_valid || out_ready; in_ready = en.
- A transfer happens when valid and ready are both high in the same cycle.
- When en=0, every stage holds, including the data, mode and valid bits.
- out_p and out_approx are stable while out_valid=1 and out_ready=0.
- Bubbles are not collapsed; an empty slot advances like data.
- Asserting rst_n low clears all valid bits, out_p, out_approx and err_cnt to 0 immediately. In-flight transactions are discarded.
- in_ready is 0 during reset and 1 in the first cycle after release.
- in_a, in_b and in_approx are don't-care when in_valid=0.

## Configuration
- APPROX_MULT_ERRSTAT_EN defined: a parallel exact product travels down the pipe.
  - err_cnt increments on each output transfer where the approximate result differs from exact.
  - err_cnt saturates at 16'hFFFF.
  - stat_clr zeroes err_cnt synchronously. If stat_clr coincides with a counting transfer, the clear wins.
- APPROX_MULT_ERRSTAT_EN undefined: no exact shadow path, no stat_clr or err_cnt ports, zero added area.

## Structure
- Package approx_mult_pkg holds:
  - TILE_W=4.
  - function n_tiles(WIDTH).
  - function pipe_latency(WIDTH).
  - tile index/shift helper functions.
- Sub-module lm_tile_4x4 is a combinational 4x4 tile with an approx enable, one instance per tile. The top generates the tiles and the registered adder tree.

## Test plan
- WIDTH=8, APPROX_DIAG=1; in_a=8'h03, in_b=8'h03, in_approx=1 -> out_p=7 after 4 cycles, out_approx=1. Same operands with in_approx=0 -> out_p=9.
- in_a=8'hFF, in_b=8'hFF: approx -> 65015, exact -> 65025. With APPROX_DIAG=0, approx -> 65025.
- Back-to-back stream of 20 random pairs with out_ready=1 -> one result per cycle, in order, each matching the reference model.
- out_ready low for 3 cycles mid-stream -> in_ready low for those 3 cycles, out_p held, no loss or duplication.
- rst_n pulsed low with 3 transactions in flight -> out_valid=0 at once, no stale result after release.
- ERRSTAT_EN build: transactions 3x3 approx, 3x3 exact, FFxFF approx -> err_cnt=2. Then stat_clr -> err_cnt=0.
